// File: rtl/quant_pkg.sv
// Shared requantization constants: width-derived min/max, OUT_W clamp bounds, rounding nudges.
// No logic; values are returned 64-bit signed and sized at the point of use.
package quant_pkg;

    localparam int DEF_ACC_W   = 32;
    localparam int DEF_MULT_W  = 32;
    localparam int DEF_SHIFT_W = 5;
    localparam int DEF_ZP_W    = 9;
    localparam int DEF_OUT_W   = 8;

    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] umax(input int w);
        return (64'sd1 <<< w) - 64'sd1;
    endfunction

    // Half an LSB of the Q(MULT_W-1) high product, mirrored for negative products.
    function automatic logic signed [63:0] nudge_pos(input int mult_w);
        return 64'sd1 <<< (mult_w - 2);
    endfunction

    function automatic logic signed [63:0] nudge_neg(input int mult_w);
        return 64'sd1 - nudge_pos(mult_w);
    endfunction

    // Added to negative dividends so an arithmetic shift truncates toward zero.
    function automatic logic signed [63:0] trunc_bias(input int mult_w);
        return (64'sd1 <<< (mult_w - 1)) - 64'sd1;
    endfunction

endpackage

// File: rtl/rounding_shift.sv
// Rounding arithmetic right shift (ties away from zero); combinational, 0 latency.
// No flow control of its own; the enclosing pipeline stage registers the result.
module rounding_shift #(
    parameter int W       = 32,
    parameter int SHIFT_W = 5
) (
    input  logic signed [W-1:0]       x,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [W-1:0]       y
);

    logic        [W-1:0] mask;
    logic        [W-1:0] rem;
    logic        [W-1:0] thr;
    logic signed [W-1:0] sh;

    always_comb begin
        mask = (W'(1) << shift) - W'(1);
        rem  = x & mask;
        thr  = (mask >> 1) + W'(x[W-1]);
        sh   = x >>> shift;
        y    = sh + W'(rem > thr);
    end

endmodule

// File: rtl/requant_pipe.sv
// Requantize acc*mult -> rounding high-mul -> rounding shift -> +zp -> clamp; latency 4, 1 beat/cycle.
// Global stall: every stage holds while the output is valid and not accepted; in_ready = stage enable.
module requant_pipe
    import quant_pkg::*;
#(
    parameter int ACC_W   = DEF_ACC_W,
    parameter int MULT_W  = DEF_MULT_W,
    parameter int SHIFT_W = DEF_SHIFT_W,
    parameter int ZP_W    = DEF_ZP_W,
    parameter int OUT_W   = DEF_OUT_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [ACC_W-1:0]   in_acc,
    input  logic signed [MULT_W-1:0]  in_mult,
    input  logic        [SHIFT_W-1:0] in_shift,
    input  logic signed [ZP_W-1:0]    in_zp,
    input  logic                      in_unsigned,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [OUT_W-1:0]   out_q
);

    localparam int P_W = ACC_W + MULT_W;
    localparam int S_W = P_W + 1;
    localparam int Z_W = ACC_W + 1;

    localparam logic signed [ACC_W-1:0]  MIN_ACC    = ACC_W'(smin(ACC_W));
    localparam logic signed [ACC_W-1:0]  MAX_ACC    = ACC_W'(smax(ACC_W));
    localparam logic signed [MULT_W-1:0] MIN_MULT   = MULT_W'(smin(MULT_W));
    localparam logic signed [S_W-1:0]    NUDGE_P    = S_W'(nudge_pos(MULT_W));
    localparam logic signed [S_W-1:0]    NUDGE_N    = S_W'(nudge_neg(MULT_W));
    localparam logic signed [S_W-1:0]    TRUNC_BIAS = S_W'(trunc_bias(MULT_W));
    localparam logic signed [Z_W-1:0]    Z_SMIN     = Z_W'(smin(OUT_W));
    localparam logic signed [Z_W-1:0]    Z_SMAX     = Z_W'(smax(OUT_W));
    localparam logic signed [Z_W-1:0]    Z_UMAX     = Z_W'(umax(OUT_W));

    typedef struct packed {
        logic        [SHIFT_W-1:0] shift;
        logic signed [ZP_W-1:0]    zp;
        logic                      uns;
    } side_t;

    typedef struct packed {
        logic signed [ZP_W-1:0] zp;
        logic                   uns;
    } tail_t;

    typedef struct packed {
        logic                   vld;
        logic signed [P_W-1:0]  p;
        logic                   sat;
        side_t                  side;
    } s1_t;

    typedef struct packed {
        logic                    vld;
        logic signed [ACC_W-1:0] x;
        side_t                   side;
    } s2_t;

    typedef struct packed {
        logic                    vld;
        logic signed [ACC_W-1:0] y;
        tail_t                   tail;
    } s3_t;

    s1_t s1, s1_nxt;
    s2_t s2, s2_nxt;
    s3_t s3, s3_nxt;
    logic             v4;
    logic [OUT_W-1:0] q4, q4_nxt;
    logic             en;

    logic signed [S_W-1:0]   sum;
    logic signed [S_W-1:0]   biased;
    logic signed [ACC_W-1:0] y3;
    logic signed [Z_W-1:0]   z, lo, hi, zc;

    assign en        = out_ready | ~v4;
    assign in_ready  = en;
    assign out_valid = v4;
    assign out_q     = q4;

    always_comb begin
        s1_nxt            = '0;
        s1_nxt.vld        = in_valid;
        s1_nxt.p          = P_W'(in_acc) * P_W'(in_mult);
        s1_nxt.sat        = (in_acc == MIN_ACC) && (in_mult == MIN_MULT);
        s1_nxt.side.shift = in_shift;
        s1_nxt.side.zp    = in_zp;
        s1_nxt.side.uns   = in_unsigned;
    end

    // Sign of p equals sign of p+nudge, so p's MSB picks both nudge and truncation bias.
    always_comb begin
        s2_nxt      = '0;
        sum         = S_W'(s1.p) + (s1.p[P_W-1] ? NUDGE_N : NUDGE_P);
        biased      = s1.p[P_W-1] ? sum + TRUNC_BIAS : sum;
        s2_nxt.vld  = s1.vld;
        s2_nxt.x    = s1.sat ? MAX_ACC : ACC_W'(biased >>> (MULT_W - 1));
        s2_nxt.side = s1.side;
    end

    rounding_shift #(
        .W       (ACC_W),
        .SHIFT_W (SHIFT_W)
    ) u_rounding_shift (
        .x     (s2.x),
        .shift (s2.side.shift),
        .y     (y3)
    );

    always_comb begin
        s3_nxt          = '0;
        s3_nxt.vld      = s2.vld;
        s3_nxt.y        = y3;
        s3_nxt.tail.zp  = s2.side.zp;
        s3_nxt.tail.uns = s2.side.uns;
    end

    always_comb begin
        z  = Z_W'(s3.y) + Z_W'(s3.tail.zp);
        lo = s3.tail.uns ? '0 : Z_SMIN;
        hi = s3.tail.uns ? Z_UMAX : Z_SMAX;
        zc = z;
        if (z < lo) begin
            zc = lo;
        end else if (z > hi) begin
            zc = hi;
        end
        q4_nxt = OUT_W'(zc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
            v4 <= 1'b0;
            q4 <= '0;
        end else if (en) begin
            s1 <= s1_nxt;
            s2 <= s2_nxt;
            s3 <= s3_nxt;
            v4 <= s3.vld;
            q4 <= q4_nxt;
        end
    end

endmodule

// File: tb/tb_requant_pipe.sv
// Randomized and directed bench for requant_pipe against an arithmetic reference model.
module tb_requant_pipe;

    localparam longint TWO30   = longint'(1) <<< 30;
    localparam longint TWO31   = longint'(1) <<< 31;
    localparam longint ACC_MIN = -TWO31;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_acc;
    logic signed [31:0] in_mult;
    logic        [4:0]  in_shift;
    logic signed [8:0]  in_zp;
    logic               in_unsigned;
    logic               out_valid;
    logic               out_ready;
    logic        [7:0]  out_q;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_q = '0;

    requant_pipe dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_acc      (in_acc),
        .in_mult     (in_mult),
        .in_shift    (in_shift),
        .in_zp       (in_zp),
        .in_unsigned (in_unsigned),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_q       (out_q)
    );

    always #5 clk = ~clk;

    // Reference: Q31 rounding multiply, round-half-away-from-zero divide, add zp, clamp.
    function automatic logic [7:0] model(input longint acc, input longint mult, input int sh,
                                         input longint zp, input bit uns);
        longint p, x, a, ya, y, z, lo, hi;
        p = acc * mult;
        if (acc == ACC_MIN && mult == ACC_MIN) x = TWO31 - 1;
        else if (p >= 0) x = (p + TWO30) / TWO31;
        else x = (p + 1 - TWO30) / TWO31;
        if (sh == 0) begin
            y = x;
        end else begin
            a  = (x < 0) ? -x : x;
            ya = (a + (longint'(1) <<< (sh - 1))) >>> sh;
            y  = (x < 0) ? -ya : ya;
        end
        z  = y + zp;
        lo = uns ? 0 : -128;
        hi = uns ? 255 : 127;
        if (z < lo) z = lo;
        if (z > hi) z = hi;
        return z[7:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
            check("reset_out_valid", 64'(out_valid), 64'd0);
        end else begin
            if (prev_stall) begin
                check("stall_valid_hold", 64'(out_valid), 64'd1);
                check("stall_q_hold", 64'(out_q), 64'(prev_q));
            end
            check("no_spurious_out", 64'(out_valid && exp_q.size() == 0), 64'd0);
            if (out_valid && out_ready && exp_q.size() > 0) begin
                check("model_out_q", 64'(out_q), 64'(exp_q.pop_front()));
                out_log.push_back(out_q);
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(in_acc, in_mult, int'(in_shift), in_zp, in_unsigned));
            prev_stall = out_valid && !out_ready;
            prev_q     = out_q;
        end
    end

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input longint acc, input longint mult, input int sh,
                         input longint zp, input bit uns);
        in_valid    = 1'b1;
        in_acc      = 32'(acc);
        in_mult     = 32'(mult);
        in_shift    = 5'(sh);
        in_zp       = 9'(zp);
        in_unsigned = uns;
    endtask

    task automatic send_one(input string name, input longint acc, input longint mult, input int sh,
                            input longint zp, input bit uns, input logic [7:0] exp8);
        idle(5);
        drive(acc, mult, sh, zp, uns);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({name, "_lat3_idle"}, 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        check({name, "_lat4_valid"}, 64'(out_valid), 64'd1);
        check({name, "_q"}, 64'(out_q), 64'(exp8));
    endtask

    task automatic backpressure();
        int  stall;
        bit  got;
        idle(6);
        out_log.delete();
        out_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            drive(k, TWO31 - 1, 0, 0, 1'b0);
            stall = 0;
            got   = 1'b0;
            for (int w = 0; w < 20 && !got; w++) begin
                @(negedge clk);
                if (k == 5 && w == 0) check("bp_in_ready_low", 64'(in_ready), 64'd0);
                if (in_ready) begin
                    got = 1'b1;
                end else begin
                    stall++;
                    if (stall == 3) begin
                        @(posedge clk); #1;
                        out_ready = 1'b1;
                    end
                end
            end
            if (!got) check("bp_accept_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("bp_count", 64'(out_log.size()), 64'd6);
        for (int k = 0; k < 6 && k < out_log.size(); k++)
            check("bp_order", 64'(out_log[k]), 64'(k + 1));
    endtask

    task automatic reset_midstream();
        idle(6);
        out_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            drive(10 * k, TWO31 - 1, 0, 0, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_out_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'd0);
        check("rst_async_out_q", 64'(out_q), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("rst_no_stale", 64'(out_valid), 64'd0);
        send_one("rst_next", 7, TWO31 - 1, 0, 0, 1'b0, 8'd7);
    endtask

    task automatic random_phase(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            r = $urandom_range(0, 9);
            drive((r == 0) ? ACC_MIN :
                  (r < 4)  ? longint'($signed(32'($urandom_range(0, 4000)) - 32'd2000)) :
                             longint'($signed(32'($urandom))),
                  ($urandom_range(0, 9) == 0) ? ACC_MIN : longint'($signed(32'($urandom))),
                  int'($urandom_range(0, 31)),
                  longint'($signed(9'($urandom))),
                  1'($urandom));
            in_valid = ($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_acc      = '0;
        in_mult     = '0;
        in_shift    = '0;
        in_zp       = '0;
        in_unsigned = 1'b0;
        out_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_q", 64'(out_q), 64'd0);
        check("reset_out_valid_rel", 64'(out_valid), 64'd0);

        send_one("basic_round", 1000, 2014687024, 8, 0, 1'b0, 8'd4);
        send_one("neg_round_s", -1000, 2014687024, 8, 10, 1'b0, 8'd6);
        send_one("neg_round_u", -1000, 2014687024, 8, 128, 1'b1, 8'd124);
        send_one("sat_pos_s", 100000, TWO30, 0, 0, 1'b0, 8'd127);
        send_one("sat_pos_u", 100000, TWO30, 0, 0, 1'b1, 8'd255);
        send_one("sat_neg_s", -100000, TWO30, 0, 0, 1'b0, 8'h80);
        send_one("sat_neg_u", -100000, TWO30, 0, 0, 1'b1, 8'd0);
        send_one("ovf_corner", ACC_MIN, ACC_MIN, 24, 0, 1'b0, 8'd127);

        backpressure();
        reset_midstream();
        random_phase(700);
        idle(12);
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/requant_pipe.md
Name: requant_pipe

Overview:
- Parametrised, fully pipelined requantization unit: accumulator × Q(MULT_W−1) multiplier → rounding doubling high-mul → rounding right shift → zero-point add → saturate to OUT_W.
- Multiplier, shift, zero point and signedness travel with every beat, so per-channel quantization needs no reconfiguration.
- Sits between the convolution/dense accumulators and the activation buffer; accepts one beat per cycle with valid/ready backpressure.

Parameters:
- ACC_W, 32, accumulator width (signed).
- MULT_W, 32, multiplier width; value is signed fixed point with MULT_W−1 fraction bits.
- SHIFT_W, 5, right-shift field width; legal shift 0..ACC_W−1.
- ZP_W, 9, zero-point width (signed).
- OUT_W, 8, output code width.

Ports:
- clk, in, 1, clock; all state updates on rising edge.
- rst_n, in, 1, reset; asynchronous, active-low.
- in_valid, in, 1, input beat valid.
- in_ready, out, 1, unit can accept a beat this cycle.
- in_acc, in, ACC_W, signed accumulator.
- in_mult, in, MULT_W, signed multiplier (Q0.MULT_W−1).
- in_shift, in, SHIFT_W, rounding right-shift amount.
- in_zp, in, ZP_W, signed zero point.
- in_unsigned, in, 1, 0 = clamp to signed OUT_W range; 1 = clamp to unsigned range.
- out_valid, out, 1, result valid.
- out_ready, in, 1, downstream accepts.
- out_q, out, OUT_W, quantized code (two's complement if signed mode).

Behaviour:
- Reset: all stage valid bits clear; out_valid=0, out_q=0, in_ready=1 once rst_n high. Reset mid-operation discards in-flight beats, with no output.
- Four-stage pipeline, latency 4 cycles from accepted beat to out_valid with out_ready held high; throughput 1 beat/cycle.
- Global stall: en = out_ready | ~v4; all stages shift only when en; in_ready = en. Bubbles are not collapsed; beats stay in order, none lost or duplicated.
- An input beat is accepted iff in_valid & in_ready. When in_valid=0 during en, a bubble enters S1.
- Stage 1 (product):
  - p = in_acc × in_mult, full ACC_W+MULT_W signed product.
  - sat_flag = (in_acc == MIN_ACC) & (in_mult == MIN_MULT).
  - Register the side fields (shift, zp, mode).
- Stage 2 (doubling high-mul):
  - nudge = p≥0 ? 2^(MULT_W−2) : 1−2^(MULT_W−2).
  - x = (p + nudge) / 2^(MULT_W−1), using division that truncates toward zero.
  - If sat_flag, x = MAX_ACC.
  - x is ACC_W signed.
- Stage 3 (rounding divide by power of two):
  - mask = 2^shift − 1; rem = x & mask; thr = (mask>>1) + (x<0).
  - y = (x >>> shift) + (rem > thr), unsigned compare.
  - shift=0 gives y=x.
- Stage 4 (zero point and saturate):
  - z = y + sign-extended zp, computed in ACC_W+1 bits with no overflow.
  - Clamp z to [−2^(OUT_W−1), 2^(OUT_W−1)−1] when signed, or [0, 2^OUT_W−1] when unsigned.
  - Register out_q and set v4.
- out_q and out_valid hold stable while out_valid & ~out_ready.
- Shift ≥ ACC_W is illegal; the result is don't-care but must not hang the pipeline.

Decomposition:
- Shared package quant_pkg holds:
  - MIN/MAX helper constants for ACC_W and MULT_W.
  - Signed/unsigned OUT_W clamp bounds.
  - The nudge constants.
- One natural sub-module, rounding_shift (stage 3: mask, threshold, shift, increment). It is reused by the pooling requantizer.

Test Plan:
- Basic rounding: acc=1000, mult=2014687024, shift=8, zp=0, signed → out_q=4, exactly 4 cycles after accept.
- Negative rounding: acc=−1000, same mult/shift, zp=10, signed → 6; same beat with zp=128, unsigned → 124.
- Saturation: acc=100000, mult=2^30, shift=0, zp=0 → signed 127, unsigned 255. acc=−100000 → signed −128, unsigned 0.
- Overflow corner: acc=mult=−2^31, shift=24, zp=0, signed → x=2^31−1, y=128, out_q=127.
- Backpressure: out_ready=0, stream 6 beats with values 1..6 (mult=2^31−1, shift=0) → in_ready drops once 4 are held. Raise out_ready → codes 1..6 in order, none duplicated or lost. out_q stable while stalled.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight → out_valid=0 immediately (async). After release, no stale output; next beat arrives with latency 4.
